// File: rtl/can_rx_frame_packer.sv
// can_rx_frame_packer
// Collects one received CAN/CAN FD frame as a byte stream, packs it little-endian
// into 32-bit words in a local buffer, and bursts the words to the RX FIFO as one
// contiguous wr run once the frame ends cleanly and passes acceptance filtering.
// Errored, rejected, empty or oversized frames never reach the FIFO.
module can_rx_frame_packer #(
  parameter int MAX_BYTES = 69
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_mode,
  input  logic        rx_sof,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eof_ok,
  input  logic        rx_err,
  input  logic        id_ok,
  output logic        wr,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        frame_dropped
);

  localparam int DEPTH = (MAX_BYTES + 3) / 4;
  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, GAP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fbuf [DEPTH];
  logic [6:0]  byte_cnt;
  logic        trunc;
  logic [4:0]  rd_idx;
  logic        drop_pend;

  logic [4:0]  word_cnt;
  logic        start;
  logic [6:0]  cnt_base;
  logic        trunc_base;
  logic        store;
  logic        accept;
  logic        last_word;

  logic        wr_nxt;
  logic [31:0] data_nxt;
  logic        drop_nxt;

  // A start-of-frame seen in IDLE or COLLECT opens a fresh frame; a byte valid in
  // that same cycle becomes byte 0, so counters are taken from zero in that cycle.
  // Bytes arriving in an eof/err cycle are not part of the frame.
  assign word_cnt   = 5'((byte_cnt + 7'd3) >> 2);
  assign start      = rx_sof && ((state == IDLE) || (state == COLLECT));
  assign cnt_base   = start ? 7'd0 : byte_cnt;
  assign trunc_base = start ? 1'b0 : trunc;
  assign store      = rx_byte_valid &&
                      (start || ((state == COLLECT) && !rx_eof_ok && !rx_err));
  assign accept     = id_ok && !trunc && (byte_cnt != 7'd0);
  assign last_word  = (rd_idx >= word_cnt);
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; reset_mode aborts from any state
  always_comb begin
    state_nxt = state;
    if (reset_mode) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rx_sof) state_nxt = COLLECT;
        COLLECT: begin
          if (rx_sof)         state_nxt = COLLECT;
          else if (rx_err)    state_nxt = IDLE;
          else if (rx_eof_ok) state_nxt = accept ? DRAIN : IDLE;
        end
        DRAIN:   if (last_word) state_nxt = GAP;
        GAP:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode for the registered FIFO interface. A restart seen during the
  // burst is held pending and reported only once wr has dropped.
  always_comb begin
    wr_nxt   = 1'b0;
    data_nxt = data_out;
    drop_nxt = 1'b0;
    if (!reset_mode) begin
      case (state)
        COLLECT: begin
          if (rx_sof || rx_err) begin
            drop_nxt = 1'b1;
          end else if (rx_eof_ok) begin
            if (accept) begin
              wr_nxt   = 1'b1;
              data_nxt = fbuf[0];
            end else begin
              drop_nxt = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!last_word) begin
            wr_nxt   = 1'b1;
            data_nxt = fbuf[rd_idx];
          end else begin
            drop_nxt = drop_pend || rx_sof;
          end
        end
        GAP:     drop_nxt = rx_sof;
        default: ;
      endcase
    end
  end

  // Registered FIFO-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr            <= 1'b0;
      data_out      <= 32'd0;
      frame_dropped <= 1'b0;
    end else begin
      wr            <= wr_nxt;
      data_out      <= data_nxt;
      frame_dropped <= drop_nxt;
    end
  end

  // Frame bookkeeping: byte count, sticky truncation, drain pointer, pending drop
  always_ff @(posedge clk) begin
    if (rst || reset_mode) begin
      byte_cnt  <= 7'd0;
      trunc     <= 1'b0;
      rd_idx    <= 5'd0;
      drop_pend <= 1'b0;
    end else begin
      if (store) begin
        if (cnt_base == MAX_CNT) begin
          byte_cnt <= cnt_base;
          trunc    <= 1'b1;
        end else begin
          byte_cnt <= cnt_base + 7'd1;
          trunc    <= trunc_base;
        end
      end else if (start) begin
        byte_cnt <= 7'd0;
        trunc    <= 1'b0;
      end

      if (state == COLLECT)
        rd_idx <= 5'd1;
      else if ((state == DRAIN) && !last_word)
        rd_idx <= rd_idx + 5'd1;

      if ((state == DRAIN) && !last_word)
        drop_pend <= drop_pend || rx_sof;
      else
        drop_pend <= 1'b0;
    end
  end

  // Frame buffer write; opening a word at lane 0 clears its upper lanes so a
  // partial final word is zero-padded
  always_ff @(posedge clk) begin
    if (store && !reset_mode && (cnt_base != MAX_CNT)) begin
      if (cnt_base[1:0] == 2'd0)
        fbuf[cnt_base[6:2]] <= {24'd0, rx_byte};
      else
        fbuf[cnt_base[6:2]][{cnt_base[1:0], 3'b000} +: 8] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_can_rx_frame_packer.sv
// Testbench for can_rx_frame_packer: directed frames plus randomized frames
// checked against a byte-list packing model.
module tb_can_rx_frame_packer;

  localparam int MAXB = 69;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mode;
  logic        rx_sof;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_eof_ok;
  logic        rx_err;
  logic        id_ok;
  logic        wr;
  logic [31:0] data_out;
  logic        busy;
  logic        frame_dropped;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fb[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  int          bursts  = 0;
  int          drops   = 0;
  int          overlap = 0;
  logic        prev_wr = 1'b0;

  can_rx_frame_packer #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .reset_mode(reset_mode), .rx_sof(rx_sof),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_eof_ok(rx_eof_ok),
    .rx_err(rx_err), .id_ok(id_ok), .wr(wr), .data_out(data_out), .busy(busy),
    .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  // FIFO-side observer
  always @(negedge clk) begin
    if (wr) got.push_back(data_out);
    if (wr && !prev_wr) bursts++;
    prev_wr = wr;
    if (frame_dropped) drops++;
    if (frame_dropped && wr) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rx_sof = 0; rx_byte_valid = 0; rx_byte = 8'h00;
    rx_eof_ok = 0; rx_err = 0; id_ok = 0;
  endtask

  task automatic clear_mon();
    got.delete(); bursts = 0; drops = 0;
  endtask

  task automatic fill_rand(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  // Reference: bytes in arrival order packed little-endian, zero-padded
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 0) exp_q.push_back(32'd0);
      exp_q[i / 4] = exp_q[i / 4] | (32'(fb[i]) << (8 * (i % 4)));
    end
  endtask

  // mode 0: eof_ok, 1: err, 2: err and eof_ok together
  task automatic send_frame(input int n, input bit idok, input int mode, input bit gaps);
    rx_sof = 1;
    if (n > 0) begin rx_byte_valid = 1; rx_byte = fb[0]; end
    cyc(); idle_inputs();
    for (int i = 1; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) cyc();
      rx_byte_valid = 1; rx_byte = fb[i];
      cyc(); idle_inputs();
    end
    if (mode != 1) begin rx_eof_ok = 1; id_ok = idok; end
    if (mode != 0) rx_err = 1;
    cyc(); idle_inputs();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin cyc(); k++; end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    cyc(); cyc();
  endtask

  task automatic check_frame(input string tag, input int n, input bit idok, input int mode);
    bit acc;
    acc = (mode == 0) && idok && (n > 0) && (n <= MAXB);
    if (acc) build_exp(n); else exp_q.delete();
    chk({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_drops"}, 32'(drops), acc ? 32'd0 : 32'd1);
    chk({tag, "_bursts"}, 32'(bursts), acc ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1; reset_mode = 0; idle_inputs();
    cyc(); cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(frame_dropped), 32'd0);

    // Standard 7-byte frame with exact burst timing
    clear_mon();
    fb = '{8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(7, 1, 0, 0);
    chk("std_t1_wr", 32'(wr), 32'd1);
    chk("std_t1_data", data_out, 32'h33221108);
    cyc();
    chk("std_t2_wr", 32'(wr), 32'd1);
    chk("std_t2_data", data_out, 32'h00665544);
    cyc();
    chk("std_gap_wr", 32'(wr), 32'd0);
    chk("std_gap_busy", 32'(busy), 32'd1);
    cyc();
    chk("std_idle_busy", 32'(busy), 32'd0);
    wait_idle();
    check_frame("std", 7, 1, 0);

    // Full FD frame
    clear_mon(); fill_rand(69); send_frame(69, 1, 0, 1); wait_idle();
    check_frame("fd69", 69, 1, 0);

    // err and eof together
    clear_mon(); fill_rand(10); send_frame(10, 1, 2, 0);
    chk("erreof_busy", 32'(busy), 32'd0);
    wait_idle();
    check_frame("erreof", 10, 1, 2);

    // Oversize, then a short frame
    clear_mon(); fill_rand(70); send_frame(70, 1, 0, 0); wait_idle();
    check_frame("over70", 70, 1, 0);
    clear_mon(); fill_rand(5); send_frame(5, 1, 0, 0); wait_idle();
    check_frame("after_over", 5, 1, 0);

    // Rejected by acceptance filter
    clear_mon(); fill_rand(12); send_frame(12, 0, 0, 0); wait_idle();
    check_frame("idrej", 12, 0, 0);

    // New frame starting during the burst is dropped, burst completes
    clear_mon(); fill_rand(69); build_exp(69);
    send_frame(69, 1, 0, 0);
    cyc(); cyc();
    rx_sof = 1; rx_byte_valid = 1; rx_byte = 8'h5A; cyc(); idle_inputs();
    for (int i = 0; i < 3; i++) begin rx_byte_valid = 1; rx_byte = 8'(i); cyc(); idle_inputs(); end
    rx_eof_ok = 1; id_ok = 1; cyc(); idle_inputs();
    wait_idle();
    chk("sofdrain_nwords", 32'(got.size()), 32'd18);
    for (int i = 0; i < got.size() && i < 18; i++)
      chk($sformatf("sofdrain_w%0d", i), got[i], exp_q[i]);
    chk("sofdrain_drops", 32'(drops), 32'd1);
    chk("sofdrain_bursts", 32'(bursts), 32'd1);

    // reset_mode in the middle of a burst
    clear_mon(); fill_rand(69);
    send_frame(69, 1, 0, 0);
    cyc(); cyc(); cyc();
    reset_mode = 1; cyc(); reset_mode = 0;
    chk("rm_wr", 32'(wr), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_words", 32'(got.size()), 32'd4);
    cyc(); cyc();
    clear_mon();
    fb = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(3, 1, 0, 0); wait_idle();
    check_frame("after_rm", 3, 1, 0);
    if (got.size() > 0) chk("after_rm_word", got[0], 32'h00CCBBAA);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int n; bit idk; int md; int r;
      n = $urandom_range(0, 74);
      idk = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      clear_mon(); fill_rand(n);
      send_frame(n, idk, md, 1); wait_idle();
      check_frame($sformatf("rnd%0d", f), n, idk, md);
    end

    chk("drop_with_wr", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
